// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants, receive state encoding and parameter
// legality checks shared by the UART receive path.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic bit params_legal(
        input int data_bits,
        input int oversample,
        input int parity_mode,
        input int stop_bits
    );
        return (data_bits >= 5) && (data_bits <= 9)
            && (oversample >= 4) && ((oversample % 2) == 0)
            && (parity_mode >= PARITY_NONE)
            && (parity_mode <= PARITY_EVEN)
            && (stop_bits >= 1) && (stop_bits <= 2);
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: received word, error flags and the valid/ack
// handshake between the deframer (master) and its consumer (slave).
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] DataParl;
    logic                 DataValid;
    logic                 DataAck;
    logic                 ParityError;
    logic                 FrameError;
    logic                 Overrun;

    modport master (
        output DataParl, DataValid, ParityError, FrameError, Overrun,
        input  DataAck
    );

    modport slave (
        input  DataParl, DataValid, ParityError, FrameError, Overrun,
        output DataAck
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: two-flop line synchroniser and bit sampler.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit.
module uart_rx_sampler #(
    parameter  int OVERSAMPLE = 16,
    localparam int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line,
    input  logic [CW-1:0] cnt,
    output logic          rx,
    output logic          bit_val,
    output logic          strobe
);
    localparam int M = OVERSAMPLE / 2;

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= line;
            s2 <= s1;
        end
    end

    assign rx = s2;

`ifdef UART_RX_MAJORITY_EN
    // h1/h2 hold rx from one and two cycles back, i.e. offsets M and M-1
    logic h1;
    logic h2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h1 <= 1'b1;
            h2 <= 1'b1;
        end else begin
            h1 <= s2;
            h2 <= h1;
        end
    end

    assign bit_val = (s2 & h1) | (s2 & h2) | (h1 & h2);
    assign strobe  = (cnt == CW'(M + 1));
`else
    assign bit_val = s2;
    assign strobe  = (cnt == CW'(M));
`endif

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: parametrised UART receive deframer with valid/ack
// output handshake; UART_RX_MAJORITY_EN enables 3-sample bit voting.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic               BaudOut,
    input  logic               ResetN,
    input  logic               DataTx,
    input  logic               RxEnable,
    output logic               Busy,
    uart_rx_deframer_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

    if (!params_legal(DATA_BITS, OVERSAMPLE, PARITY_MODE, STOP_BITS))
    begin : g_bad_params
        $fatal(1, "uart_rx_deframer: illegal parameter set");
    end

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pe_pend;
    logic                 fe_pend;
    logic                 rx;
    logic                 bit_val;
    logic                 strobe;
    logic                 wrap;
    logic                 last_data;
    logic                 start_det;
    logic                 shift_en;
    logic                 par_chk;
    logic                 stop_chk;
    logic                 commit;
    logic                 exp_par;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk    (BaudOut),
        .rst_n  (ResetN),
        .line   (DataTx),
        .cnt    (cnt),
        .rx     (rx),
        .bit_val(bit_val),
        .strobe (strobe)
    );

    assign wrap      = (cnt == LAST_TICK);
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign exp_par   = (PARITY_MODE == PARITY_ODD) ? ~^shreg : ^shreg;
    assign Busy      = (state != ST_IDLE);

    always_ff @(posedge BaudOut) begin
        if (!ResetN) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rx && RxEnable) begin
                    start_det = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (strobe && bit_val) state_nxt = ST_IDLE;
                else if (wrap)         state_nxt = ST_DATA;
            end
            ST_DATA: begin
                shift_en = strobe;
                if (wrap && last_data)
                    state_nxt = (PARITY_MODE != PARITY_NONE)
                              ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                par_chk = strobe;
                if (wrap) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                stop_chk = strobe;
                // commit on the last stop decision so the next start edge is not missed
                if (strobe && bit_idx == 4'(STOP_BITS - 1)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge BaudOut) begin
        if (!ResetN) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            pe_pend <= 1'b0;
            fe_pend <= 1'b0;
        end else begin
            if (state == ST_IDLE) cnt <= start_det ? CW'(1) : '0;
            else                  cnt <= wrap ? '0 : cnt + 1'b1;

            unique case (state)
                ST_DATA: if (wrap) bit_idx <= last_data ? '0 : bit_idx + 1'b1;
                ST_STOP: if (wrap) bit_idx <= bit_idx + 1'b1;
                default: bit_idx <= '0;
            endcase

            if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};

            if (start_det) begin
                pe_pend <= 1'b0;
                fe_pend <= 1'b0;
            end else begin
                if (par_chk)              pe_pend <= (bit_val != exp_par);
                if (stop_chk && !bit_val) fe_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge BaudOut) begin
        if (!ResetN) begin
            bus.DataParl    <= '0;
            bus.DataValid   <= 1'b0;
            bus.ParityError <= 1'b0;
            bus.FrameError  <= 1'b0;
            bus.Overrun     <= 1'b0;
        end else if (commit) begin
            bus.DataParl    <= shreg;
            bus.ParityError <= pe_pend;
            bus.FrameError  <= fe_pend | ~bit_val;
            bus.DataValid   <= 1'b1;
            if (bus.DataValid && !bus.DataAck) bus.Overrun <= 1'b1;
        end else if (bus.DataAck) begin
            bus.DataValid <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Parametrised UART receive deframer, the successor to the fixed 11-bit shift-register receiver. It samples the synchronised serial line at an oversampled baud clock, detects and qualifies the start bit, and shifts in a configurable number of data bits. It then checks optional parity and one or two stop bits, and presents the word with a valid/acknowledge handshake and error flags. It sits between the baud generator and the receive FIFO/host interface of the UART-Rx path.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9, LSB first on the line
- OVERSAMPLE, 16: BaudOut cycles per bit; even, >= 4
- PARITY_MODE, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- BaudOut  in  1  sole clock, OVERSAMPLE x bit rate; all logic on rising edge
- ResetN  in  1  synchronous, active-low reset
- DataTx  in  1  asynchronous serial line, idle high
- RxEnable  in  1  when low, no new frame is started; a frame in progress completes
- DataAck  in  1  consumer accepts DataParl when DataValid is high
- DataParl  out  DATA_BITS  received word, bit 0 = first data bit on line
- DataValid  out  1  word available; held until DataAck
- ParityError  out  1  parity mismatch for the word in DataParl
- FrameError  out  1  any stop bit sampled low for the word in DataParl
- Overrun  out  1  sticky; a frame completed while DataValid was high
- Busy  out  1  high in every state except IDLE

## Operation
- Input path: two-flop synchroniser on DataTx, both flops reset to 1; the result is the synchronised line, rx.
- States: IDLE, START, DATA, PARITY (only if PARITY_MODE != 0), STOP.
- IDLE: tick counter cleared. rx low with RxEnable high -> START, counter = 1. That cycle is T0.
- Counter runs 0..OVERSAMPLE-1 and wraps; each wrap is one bit period. Sample point is M = OVERSAMPLE/2 cycles into each bit.
- START: sampled value 1 is a false start -> IDLE with no flags changed. Sampled value 0 -> DATA at the end of the bit period.
- DATA: the sample is shifted into an internal register, LSB first. After DATA_BITS samples -> PARITY or STOP.
- PARITY: expected bit = XOR of data (even) or its inverse (odd). A mismatch sets the pending parity error.
- STOP: STOP_BITS samples. Any 0 sets the pending frame error. At the last stop sample: commit and go to IDLE at once, without waiting for the end of the bit, so the next falling edge is caught.
- Commit: DataParl <= shift reg, ParityError/FrameError <= pending, DataValid <= 1. If DataValid was already high and not acked that cycle, Overrun <= 1 and the old word is overwritten by the new one.
- DataAck with DataValid high: DataValid <= 0 next cycle. A commit in the same cycle wins: DataValid stays 1 and Overrun is not set.
- Overrun clears only on reset.
- DataAck while DataValid is low is ignored.

## Timing
- Reset: state IDLE, DataParl 0, DataValid 0, ParityError 0, FrameError 0, Overrun 0, Busy 0, counter 0, shift reg 0.
- Reset asserted mid-frame abandons the frame. No flags are set.
- Line-to-rx latency: 2 cycles.
- Sample of bit k (start = 0): T0 + M + k*OVERSAMPLE. With majority voting the decision is 1 cycle later.
- DataValid rises the cycle after the last stop decision. For 8N1 at OVERSAMPLE 16 without majority: T0 + 153.
- Busy rises at T0 and falls with commit or false start.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of rx at offsets M-1, M, M+1. All state decisions move to M+1.
- Not defined: a single sample at M.
- Handshake, flags and state sequence are identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - parity-mode constants PARITY_NONE/ODD/EVEN
  - the state encoding
  - the parameter legality checks (DATA_BITS range, OVERSAMPLE even and >= 4, STOP_BITS 1..2)
- One sub-module, uart_rx_sampler: synchroniser plus optional majority vote. Outputs the bit value and a sample-strobe from the tick counter.

## Test plan
- 8N1, OVERSAMPLE 16, send 0xA5 -> DataParl 0xA5, DataValid at T0+153 (T0+154 with majority), no error flags.
- 7E1, send 0x41 with wrong parity bit -> DataParl 0x41, ParityError 1, FrameError 0.
- 8N2, second stop bit driven low -> FrameError 1, word still committed.
- Line low for 4 cycles then high (glitch) -> START rejects, returns to IDLE, DataValid stays 0, Busy pulses.
- Two back-to-back frames 0x11, 0x22 with no DataAck -> DataParl 0x22, Overrun 1. Then DataAck -> DataValid 0, Overrun stays 1.
- ResetN low for one cycle during data bit 3 -> all outputs 0. The next full frame 0x3C is received correctly.
